// File: rtl/multi_ball_hit_tracker_pkg.sv
// Shared FSM state, coordinate type and screen constants for the multi-ball hit tracker.
package multi_ball_hit_tracker_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef logic [9:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_ball_hit_tracker_ball_box_counter.sv
// Per-ball box test, saturating target-pixel counter and end-of-frame snapshot register.
module ball_box_counter
    import multi_ball_hit_tracker_pkg::*;
#(
    parameter int BALL_SIZE = 32,
    parameter int CNT_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  coord_t           x_i,
    input  coord_t           y_i,
    input  logic             de_i,
    input  logic             target_i,
    input  coord_t           ball_x_i,
    input  coord_t           ball_y_i,
    input  logic             active_i,
    input  logic             snap_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] snap_o
);

    localparam logic [10:0] SPAN = 11'(BALL_SIZE - 1);

    // Box limits are widened to 11 bits so a ball near x/y=1023 does not wrap.
    logic [10:0] x_w, y_w, bx_lo, by_lo, bx_hi, by_hi;
    logic             in_box;
    logic             hit_px;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;

    assign x_w   = {1'b0, x_i};
    assign y_w   = {1'b0, y_i};
    assign bx_lo = {1'b0, ball_x_i};
    assign by_lo = {1'b0, ball_y_i};
    assign bx_hi = bx_lo + SPAN;
    assign by_hi = by_lo + SPAN;

    assign in_box = (x_w >= bx_lo) && (x_w <= bx_hi) && (y_w >= by_lo) && (y_w <= by_hi);
    assign hit_px = active_i && de_i && target_i && in_box;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hit_px && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign snap_d = snap_i ? cnt_d : snap_q;
    assign snap_o = snap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

endmodule

// File: rtl/multi_ball_hit_tracker.sv
// Multi-ball hit tracker: per-frame pixel counts per ball, serial hit evaluation, handshaked report.
// Optional macro HIT_SPEED_EN adds per-ball previous-frame storage and hit_speed estimation.
module multi_ball_hit_tracker
    import multi_ball_hit_tracker_pkg::*;
#(
    parameter int NUM_BALLS       = 4,
    parameter int BALL_SIZE       = 32,
    parameter int HIT_THRESHOLD   = 64,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int CNT_W           = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x_pixel,
    input  logic [9:0]              y_pixel,
    input  logic                    DE,
    input  logic                    frame_end,
    input  logic                    is_target_color,
    input  logic [10*NUM_BALLS-1:0] ball_x,
    input  logic [10*NUM_BALLS-1:0] ball_y,
    input  logic [NUM_BALLS-1:0]    ball_active,
    output logic                    hit_valid,
    input  logic                    hit_ready,
    output logic [NUM_BALLS-1:0]    hit_mask,
    output logic [7:0]              hit_speed,
    output logic [7:0]              score,
    output logic                    overrun
);

    localparam int              CD_W     = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_FRAMES);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_BALLS - 1);

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [NUM_BALLS-1:0] mask_q, mask_d;
    logic [7:0]           score_q, score_d;
    logic                 overrun_q, overrun_d;
    logic                 clear_q;
    logic                 fe_accept;

    logic [CNT_W-1:0] snap [NUM_BALLS];
    logic [CD_W-1:0]  cd_q [NUM_BALLS];
    logic [CD_W-1:0]  cd_d [NUM_BALLS];
    logic [CNT_W-1:0] sel_snap;
    logic [CD_W-1:0]  sel_cd;
    logic             sel_active;
    logic             sel_hit;

    function automatic logic [7:0] sat_score(input logic [7:0] s, input logic [3:0] add);
        logic [8:0] sum;
        sum = {1'b0, s} + {5'b00000, add};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign fe_accept = frame_end && (state_q == ACCUM);

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        ball_box_counter #(
            .BALL_SIZE(BALL_SIZE),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .clk_i   (clk),
            .rst_ni  (reset),
            .x_i     (x_pixel),
            .y_i     (y_pixel),
            .de_i    (DE),
            .target_i(is_target_color),
            .ball_x_i(ball_x[10*g +: 10]),
            .ball_y_i(ball_y[10*g +: 10]),
            .active_i(ball_active[g]),
            .snap_i  (fe_accept),
            .clear_i (clear_q),
            .snap_o  (snap[g])
        );
    end

    always_comb begin
        sel_snap   = '0;
        sel_cd     = '0;
        sel_active = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == 3'(i)) begin
                sel_snap   = snap[i];
                sel_cd     = cd_q[i];
                sel_active = ball_active[i];
            end
        end
    end

    assign sel_hit = (state_q == EVAL) && sel_active && (sel_cd == '0) &&
                     (32'(sel_snap) >= 32'(HIT_THRESHOLD));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        score_d   = score_q;
        overrun_d = overrun_q;
        case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    state_d = EVAL;
                    idx_d   = '0;
                    mask_d  = '0;
                end
            end
            EVAL: begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (sel_hit && (idx_q == 3'(i))) mask_d[i] = 1'b1;
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_IDX) state_d = (mask_d != '0) ? REPORT : ACCUM;
                if (frame_end) overrun_d = 1'b1;
            end
            REPORT: begin
                if (frame_end) overrun_d = 1'b1;
                if (hit_ready) begin
                    score_d = sat_score(score_q, popcount8(8'(mask_q)));
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Cooldown ticks during the ball's own EVAL slot, so it sees the value from before this frame.
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            cd_d[i] = cd_q[i];
            if (!ball_active[i]) begin
                cd_d[i] = '0;
            end else if ((state_q == EVAL) && (idx_q == 3'(i))) begin
                if (sel_hit) cd_d[i] = CD_LOAD;
                else if (cd_q[i] != '0) cd_d[i] = cd_q[i] - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ACCUM;
            idx_q     <= '0;
            mask_q    <= '0;
            score_q   <= '0;
            overrun_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            score_q   <= score_d;
            overrun_q <= overrun_d;
            clear_q   <= fe_accept;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BALLS; i++) cd_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) cd_q[i] <= cd_d[i];
        end
    end

    assign hit_valid = (state_q == REPORT);
    assign hit_mask  = hit_valid ? mask_q : '0;
    assign score     = score_q;
    assign overrun   = overrun_q;

`ifdef HIT_SPEED_EN
    logic [CNT_W-1:0] prev_q [NUM_BALLS];
    logic [CNT_W-1:0] sel_prev;
    logic [7:0]       speed_q, speed_d;

    function automatic logic [7:0] sat_speed(input logic [CNT_W-1:0] cur, input logic [CNT_W-1:0] prev);
        logic [CNT_W-1:0] diff;
        logic [CNT_W-1:0] sh;
        diff = (cur >= prev) ? (cur - prev) : (prev - cur);
        sh   = diff >> 2;
        return (32'(sh) > 32'd255) ? 8'hFF : 8'(sh);
    endfunction

    always_comb begin
        sel_prev = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == 3'(i)) sel_prev = prev_q[i];
        end
    end

    // Only the first (lowest-index) hit of the frame sets the reported speed.
    always_comb begin
        speed_d = speed_q;
        if (sel_hit && (mask_q == '0)) speed_d = sat_speed(sel_snap, sel_prev);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_q <= '0;
            for (int i = 0; i < NUM_BALLS; i++) prev_q[i] <= '0;
        end else begin
            speed_q <= speed_d;
            for (int i = 0; i < NUM_BALLS; i++) begin
                if ((state_q == EVAL) && (idx_q == 3'(i))) prev_q[i] <= snap[i];
            end
        end
    end

    assign hit_speed = hit_valid ? speed_q : 8'd0;
`else
    assign hit_speed = 8'd0;
`endif

endmodule

// File: tb/tb_multi_ball_hit_tracker.sv
// Directed-vector bench for multi_ball_hit_tracker; balls sit at x=100,200,300,400, y=100.
module tb_multi_ball_hit_tracker;

    localparam int NB = 4;
`ifdef HIT_SPEED_EN
    localparam int SPD_ON = 1;
`else
    localparam int SPD_ON = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [9:0]      x_pixel, y_pixel;
    logic            DE, frame_end, is_target_color;
    logic [10*NB-1:0] ball_x, ball_y;
    logic [NB-1:0]   ball_active;
    logic            hit_valid, hit_ready;
    logic [NB-1:0]   hit_mask;
    logic [7:0]      hit_speed, score;
    logic            overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 clk = ~clk;

    multi_ball_hit_tracker #(
        .NUM_BALLS(NB), .BALL_SIZE(32), .HIT_THRESHOLD(64), .COOLDOWN_FRAMES(8), .CNT_W(11)
    ) dut (
        .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(DE),
        .frame_end(frame_end), .is_target_color(is_target_color), .ball_x(ball_x),
        .ball_y(ball_y), .ball_active(ball_active), .hit_valid(hit_valid),
        .hit_ready(hit_ready), .hit_mask(hit_mask), .hit_speed(hit_speed),
        .score(score), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic paint(input int x0, input int y0, input int w, input int h);
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                x_pixel = 10'(x0 + i);
                y_pixel = 10'(y0 + j);
                DE = 1'b1;
                is_target_color = 1'b1;
                tick();
            end
        end
        DE = 1'b0;
        is_target_color = 1'b0;
    endtask

    task automatic paint_ball(input int b);
        paint(100 + 100 * b, 100, 8, 8);
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (NB) tick();
    endtask

    task automatic accept();
        hit_ready = 1'b1;
        tick();
        hit_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        x_pixel = '0;
        y_pixel = '0;
        DE = 1'b0;
        frame_end = 1'b0;
        is_target_color = 1'b0;
        hit_ready = 1'b0;
        ball_active = '1;
        for (int b = 0; b < NB; b++) begin
            ball_x[10*b +: 10] = 10'(100 + 100 * b);
            ball_y[10*b +: 10] = 10'd100;
        end
        repeat (2) tick();
        check("rst_valid", 32'(hit_valid), 0);
        check("rst_mask", 32'(hit_mask), 0);
        check("rst_speed", 32'(hit_speed), 0);
        check("rst_score", 32'(score), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        tick();

        // full 40x40 patch over ball 0
        paint(96, 96, 40, 40);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (NB - 1) tick();
        check("full_early_valid", 32'(hit_valid), 0);
        tick();
        check("full_valid", 32'(hit_valid), 1);
        check("full_mask", 32'(hit_mask), 32'b0001);
        check("full_speed", 32'(hit_speed), SPD_ON ? 255 : 0);
        accept();
        check("full_score", 32'(score), 1);
        check("full_valid_drop", 32'(hit_valid), 0);

        // threshold: 63 pixels no hit, 64 pixels hit
        do_reset();
        paint(100, 100, 9, 7);
        end_frame();
        check("thr63_valid", 32'(hit_valid), 0);
        paint_ball(0);
        end_frame();
        check("thr64_valid", 32'(hit_valid), 1);
        check("thr64_mask", 32'(hit_mask), 32'b0001);
        accept();
        check("thr64_score", 32'(score), 1);

        // box edges: column outside on the left/right is not counted
        do_reset();
        paint(99, 100, 9, 8);
        paint(225, 100, 9, 8);
        end_frame();
        check("edge_mask", 32'(hit_mask), 32'b0001);
        accept();

        // inactive balls never count
        do_reset();
        ball_active = 4'b1101;
        paint_ball(1);
        end_frame();
        check("inactive_valid", 32'(hit_valid), 0);
        ball_active = '1;

        // speed from lowest hitting ball (200 pixels, previous frame 0)
        do_reset();
        paint(100, 100, 20, 10);
        paint_ball(2);
        end_frame();
        check("speed_mask", 32'(hit_mask), 32'b0101);
        check("speed_val", 32'(hit_speed), SPD_ON ? 50 : 0);
        accept();
        check("speed_score", 32'(score), 2);

        // cooldown: 8 ignored frames, hit again on the 9th
        do_reset();
        paint_ball(0);
        paint_ball(2);
        end_frame();
        check("cd_first_mask", 32'(hit_mask), 32'b0101);
        accept();
        check("cd_first_score", 32'(score), 2);
        for (int k = 0; k < 8; k++) begin
            paint_ball(0);
            paint_ball(2);
            end_frame();
            check("cd_blocked_valid", 32'(hit_valid), 0);
        end
        paint_ball(0);
        paint_ball(2);
        end_frame();
        check("cd_ninth_mask", 32'(hit_mask), 32'b0101);
        accept();
        check("cd_ninth_score", 32'(score), 4);
        check("cd_overrun", 32'(overrun), 0);

        // overrun: frame_end while report is pending
        do_reset();
        paint_ball(0);
        end_frame();
        check("ovr_valid", 32'(hit_valid), 1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_valid_held", 32'(hit_valid), 1);
        check("ovr_mask_held", 32'(hit_mask), 32'b0001);
        check("ovr_score_held", 32'(score), 0);
        accept();
        check("ovr_score", 32'(score), 1);
        check("ovr_sticky", 32'(overrun), 1);
        check("ovr_valid_drop", 32'(hit_valid), 0);

        // score saturation, then reset during a pending report
        do_reset();
        for (int k = 0; k < 63; k++) begin
            for (int b = 0; b < NB; b++) paint_ball(b);
            end_frame();
            accept();
            repeat (8) end_frame();
        end
        check("sat_score_252", 32'(score), 252);
        paint_ball(0);
        paint_ball(2);
        end_frame();
        accept();
        check("sat_score_254", 32'(score), 254);
        paint_ball(1);
        paint_ball(3);
        end_frame();
        check("sat_mask", 32'(hit_mask), 32'b1010);
        accept();
        check("sat_score_255", 32'(score), 255);
        repeat (8) end_frame();
        paint_ball(0);
        end_frame();
        check("rstrep_valid", 32'(hit_valid), 1);
        reset = 1'b0;
        #1;
        check("rstrep_valid_clr", 32'(hit_valid), 0);
        check("rstrep_score_clr", 32'(score), 0);
        check("rstrep_mask_clr", 32'(hit_mask), 0);
        tick();
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
